// File: rtl/trigger_cascade_rx_if.sv
// Cascade trigger receiver bus: register configuration and trigger line in,
// filtered trigger and readback counters out.
interface trigger_cascade_rx_if #(
  parameter int FILT_W = 8,
  parameter int HOLD_W = 16,
  parameter int CNT_W  = 32
);
  logic              reg_slave_device;
  logic [FILT_W-1:0] reg_filt_cycles;
  logic [HOLD_W-1:0] reg_holdoff_cycles;
  logic              reg_cnt_clr;
  logic              trigger_from_master;
  logic              trigger_pulse;
  logic              trigger_level;
  logic              holdoff_busy;
  logic [CNT_W-1:0]  trigger_cnt;
  logic [CNT_W-1:0]  trigger_drop_cnt;

  modport master (
    output reg_slave_device, reg_filt_cycles, reg_holdoff_cycles, reg_cnt_clr,
           trigger_from_master,
    input  trigger_pulse, trigger_level, holdoff_busy, trigger_cnt, trigger_drop_cnt
  );

  modport slave (
    input  reg_slave_device, reg_filt_cycles, reg_holdoff_cycles, reg_cnt_clr,
           trigger_from_master,
    output trigger_pulse, trigger_level, holdoff_busy, trigger_cnt, trigger_drop_cnt
  );
endinterface

// File: rtl/trigger_cascade_rx.sv
// Cascade slave trigger receiver: synchroniser, glitch filter, holdoff and
// accepted/dropped trigger counters.
//
//   state   | meaning
//   --------+--------------------------------------------------
//   LOW     | filtered level 0, line stable low
//   RISE_Q  | line high, counting cycles towards a rising edge
//   HIGH    | filtered level 1, line stable high
//   FALL_Q  | line low, counting cycles towards a falling edge
module trigger_cascade_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 8,
  parameter int HOLD_W      = 16,
  parameter int CNT_W       = 32
) (
  input  logic clk,
  input  logic rst_n,
  trigger_cascade_rx_if.slave bus
);

  typedef enum logic [1:0] {ST_LOW, ST_RISE_Q, ST_HIGH, ST_FALL_Q} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [FILT_W-1:0]      fc;
  logic [FILT_W:0]        fc_next;
  logic [FILT_W:0]        n_eff;
  logic                   qual;
  logic                   rise;
  logic                   accept;
  logic                   drop;
  logic [HOLD_W-1:0]      holdoff;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       drop_q;
  logic [CNT_W-1:0]       cnt_base;
  logic [CNT_W-1:0]       drop_base;
  logic                   pulse_q;
  logic                   level_q;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], bus.trigger_from_master};
  end

  // fc is always 0 in LOW/HIGH, so fc_next counts the current sample too;
  // with N=1 the stable states qualify on the first differing sample.
  assign n_eff   = (bus.reg_filt_cycles == '0) ? {{FILT_W{1'b0}}, 1'b1}
                                               : {1'b0, bus.reg_filt_cycles};
  assign fc_next = {1'b0, fc} + {{FILT_W{1'b0}}, 1'b1};
  assign qual    = (fc_next >= n_eff);

  assign rise   = bus.reg_slave_device && s && qual &&
                  ((state == ST_LOW) || (state == ST_RISE_Q));
  assign accept = rise && (holdoff == '0);
  assign drop   = rise && (holdoff != '0);

  // Clear takes effect first; a same-cycle event then counts from zero.
  assign cnt_base  = bus.reg_cnt_clr ? '0 : cnt_q;
  assign drop_base = bus.reg_cnt_clr ? '0 : drop_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_LOW;
      fc      <= '0;
      holdoff <= '0;
      cnt_q   <= '0;
      drop_q  <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      pulse_q <= accept;
      cnt_q   <= cnt_base + {{(CNT_W-1){1'b0}}, accept};
      if (drop && !(&drop_base)) drop_q <= drop_base + {{(CNT_W-1){1'b0}}, 1'b1};
      else                       drop_q <= drop_base;

      if (!bus.reg_slave_device) begin
        state   <= s ? ST_HIGH : ST_LOW;
        level_q <= s;
        fc      <= '0;
        holdoff <= '0;
      end else begin
        if (accept)              holdoff <= bus.reg_holdoff_cycles;
        else if (holdoff != '0)  holdoff <= holdoff - {{(HOLD_W-1){1'b0}}, 1'b1};

        case (state)
          ST_LOW: begin
            if (s) begin
              if (qual) begin
                state   <= ST_HIGH;
                level_q <= 1'b1;
                fc      <= '0;
              end else begin
                state <= ST_RISE_Q;
                fc    <= fc_next[FILT_W-1:0];
              end
            end
          end
          ST_RISE_Q: begin
            if (!s) begin
              state <= ST_LOW;
              fc    <= '0;
            end else if (qual) begin
              state   <= ST_HIGH;
              level_q <= 1'b1;
              fc      <= '0;
            end else begin
              fc <= fc_next[FILT_W-1:0];
            end
          end
          ST_HIGH: begin
            if (!s) begin
              if (qual) begin
                state   <= ST_LOW;
                level_q <= 1'b0;
                fc      <= '0;
              end else begin
                state <= ST_FALL_Q;
                fc    <= fc_next[FILT_W-1:0];
              end
            end
          end
          default: begin
            if (s) begin
              state <= ST_HIGH;
              fc    <= '0;
            end else if (qual) begin
              state   <= ST_LOW;
              level_q <= 1'b0;
              fc      <= '0;
            end else begin
              fc <= fc_next[FILT_W-1:0];
            end
          end
        endcase
      end
    end
  end

  assign bus.trigger_pulse    = pulse_q;
  assign bus.trigger_level    = level_q;
  assign bus.holdoff_busy     = (holdoff != '0);
  assign bus.trigger_cnt      = cnt_q;
  assign bus.trigger_drop_cnt = drop_q;

endmodule

// File: tb/tb_trigger_cascade_rx.sv
// Bench for trigger_cascade_rx: directed scenarios plus random line activity
// against a run-length/timestamp reference model.
module tb_trigger_cascade_rx;
  localparam int SYNC = 2;
  localparam int FW   = 8;
  localparam int HW   = 16;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  trigger_cascade_rx_if #(.FILT_W(FW), .HOLD_W(HW), .CNT_W(CW)) bus ();

  trigger_cascade_rx #(.SYNC_STAGES(SYNC), .FILT_W(FW), .HOLD_W(HW), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  int pulses = 0;

  // Reference model: s is the input sampled SYNC edges earlier; a level change
  // is accepted once the new value has been seen for N consecutive edges.
  logic sq[$];
  int   edge_no = 0;
  logic m_level, m_pulse;
  int   run, hold_until, m_cnt, m_drop;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h at edge %0d", tag, obs, exp, edge_no);
    end
  endtask

  task automatic model_reset();
    sq.delete();
    for (int i = 0; i < SYNC; i++) sq.push_back(1'b0);
    m_level = 1'b0; m_pulse = 1'b0;
    run = 0; hold_until = edge_no; m_cnt = 0; m_drop = 0;
  endtask

  task automatic model_edge(input logic in_s, input logic sl, input logic clr,
                            input int n, input int h);
    logic s_pre;
    logic rise;
    edge_no++;
    s_pre = sq.pop_front();
    sq.push_back(in_s);
    rise = 1'b0;
    m_pulse = 1'b0;
    if (!sl) begin
      m_level = s_pre; run = 0; hold_until = edge_no;
    end else begin
      if (s_pre != m_level) run++; else run = 0;
      if (run >= ((n < 1) ? 1 : n)) begin
        m_level = s_pre; run = 0; rise = s_pre;
      end
    end
    if (clr) begin m_cnt = 0; m_drop = 0; end
    if (rise) begin
      if (edge_no <= hold_until) begin
        if (m_drop < CMAX) m_drop++;
      end else begin
        m_pulse = 1'b1;
        m_cnt = (m_cnt + 1) % (CMAX + 1);
        hold_until = edge_no + h;
      end
    end
  endtask

  task automatic check_all();
    check("trigger_level", 32'(bus.trigger_level), 32'(m_level));
    check("trigger_pulse", 32'(bus.trigger_pulse), 32'(m_pulse));
    check("holdoff_busy", 32'(bus.holdoff_busy), 32'(edge_no < hold_until));
    check("trigger_cnt", 32'(bus.trigger_cnt), 32'(m_cnt));
    check("trigger_drop_cnt", 32'(bus.trigger_drop_cnt), 32'(m_drop));
  endtask

  task automatic step();
    logic in_s, sl, clr;
    int n, h;
    in_s = bus.trigger_from_master;
    sl   = bus.reg_slave_device;
    clr  = bus.reg_cnt_clr;
    n    = int'(bus.reg_filt_cycles);
    h    = int'(bus.reg_holdoff_cycles);
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_edge(in_s, sl, clr, n, h);
    #1;
    check_all();
    if (bus.trigger_pulse === 1'b1) pulses++;
  endtask

  task automatic run_cycles(input int k);
    repeat (k) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "time limit");
  end

  initial begin
    int first, run_left, iter;
    bus.reg_slave_device    = 1'b1;
    bus.reg_filt_cycles     = 8'd4;
    bus.reg_holdoff_cycles  = '0;
    bus.reg_cnt_clr         = 1'b0;
    bus.trigger_from_master = 1'b0;
    model_reset();

    // Reset state
    run_cycles(3);
    rst_n = 1'b1;
    run_cycles(5);

    // N=4, H=0: pulse on 6th edge counting the first high sample
    bus.trigger_from_master = 1'b1;
    first = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (bus.trigger_pulse === 1'b1 && first == 0) first = i;
    end
    check("latency_n4", 32'(first), 32'd6);
    check("cnt_after_first", 32'(bus.trigger_cnt), 32'd1);

    // Short glitches in both directions are ignored
    bus.trigger_from_master = 1'b0; run_cycles(12);
    pulses = 0;
    bus.trigger_from_master = 1'b1; run_cycles(3);
    bus.trigger_from_master = 1'b0; run_cycles(10);
    check("high_glitch_pulses", 32'(pulses), 32'd0);
    check("high_glitch_level", 32'(bus.trigger_level), 32'd0);
    bus.trigger_from_master = 1'b1; run_cycles(12);
    pulses = 0;
    bus.trigger_from_master = 1'b0; run_cycles(3);
    bus.trigger_from_master = 1'b1; run_cycles(10);
    check("low_glitch_pulses", 32'(pulses), 32'd0);
    check("low_glitch_level", 32'(bus.trigger_level), 32'd1);

    // N=1, H=20: edges every 10 cycles
    bus.reg_filt_cycles = 8'd1;
    bus.reg_holdoff_cycles = 16'd20;
    bus.trigger_from_master = 1'b0; run_cycles(30);
    repeat (5) begin
      bus.trigger_from_master = 1'b1; run_cycles(5);
      bus.trigger_from_master = 1'b0; run_cycles(5);
    end
    run_cycles(25);

    // Enabling with line high gives no pulse; next clean edge gives one
    bus.reg_holdoff_cycles = '0;
    bus.reg_slave_device = 1'b0;
    bus.trigger_from_master = 1'b1; run_cycles(10);
    pulses = 0;
    bus.reg_slave_device = 1'b1; run_cycles(10);
    check("enable_high_pulses", 32'(pulses), 32'd0);
    bus.trigger_from_master = 1'b0; run_cycles(6);
    bus.trigger_from_master = 1'b1; run_cycles(8);
    check("edge_after_enable", 32'(pulses), 32'd1);

    // Clear coincident with rise event at trigger_cnt=7
    iter = 0;
    while (m_cnt != 7 && iter < 40) begin
      bus.trigger_from_master = 1'b0; run_cycles(3);
      bus.trigger_from_master = 1'b1; run_cycles(3);
      iter++;
    end
    check("cnt_preload", 32'(bus.trigger_cnt), 32'd7);
    bus.trigger_from_master = 1'b0; run_cycles(4);
    bus.trigger_from_master = 1'b1;
    step(); step();
    bus.reg_cnt_clr = 1'b1;
    step();
    bus.reg_cnt_clr = 1'b0;
    check("clr_with_event", 32'(bus.trigger_cnt), 32'd1);
    check("clr_with_event_pulse", 32'(bus.trigger_pulse), 32'd1);

    // Drop counter saturation
    bus.reg_holdoff_cycles = 16'd2000;
    repeat (20) begin
      bus.trigger_from_master = 1'b0; run_cycles(3);
      bus.trigger_from_master = 1'b1; run_cycles(3);
    end
    check("drop_saturated", 32'(bus.trigger_drop_cnt), 32'(CMAX));
    bus.reg_cnt_clr = 1'b1; step();
    bus.reg_cnt_clr = 1'b0;

    // Async reset during RISE_Q, then requalify after release
    bus.reg_holdoff_cycles = '0;
    bus.reg_filt_cycles = 8'd8;
    bus.trigger_from_master = 1'b0; run_cycles(10);
    bus.trigger_from_master = 1'b1; run_cycles(4);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    run_cycles(3);
    rst_n = 1'b1;
    first = 0;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (bus.trigger_pulse === 1'b1 && first == 0) first = i;
    end
    check("latency_after_reset", 32'(first), 32'(SYNC + 8));

    // Random line activity with occasional config changes
    run_left = 0;
    for (int c = 0; c < 3000; c++) begin
      if (run_left == 0) begin
        bus.trigger_from_master = ~bus.trigger_from_master;
        run_left = $urandom_range(1, 10);
      end
      run_left--;
      if ($urandom_range(0, 39) == 0) begin
        bus.reg_filt_cycles = 8'($urandom_range(0, 5));
        bus.reg_holdoff_cycles = 16'($urandom_range(0, 30));
      end
      if ($urandom_range(0, 59) == 0) bus.reg_slave_device = ~bus.reg_slave_device;
      bus.reg_cnt_clr = ($urandom_range(0, 24) == 0);
      step();
    end
    bus.reg_cnt_clr = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
